// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequencing and sign handling for an unsigned 32x32->64
// multiplier in the RV32M execute path. Signed operands become magnitudes
// on the way in. The product is negated on the way back when needed. A
// one-entry cache of the last corrected product lets MUL complete in one
// cycle when it follows a MULH on the same operands.
module mul_seq_ctrl #(
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic        flush,
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_out
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_FIX   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [3:0] LAT_INIT = 4'(MUL_LATENCY);

    // {A signed, B signed} for each funct3[1:0] encoding
    function automatic logic [1:0] op_signedness(input logic [1:0] op_f);
        logic [1:0] sgn_f;
        case (op_f)
            2'b00, 2'b01: sgn_f = 2'b11;
            2'b10:        sgn_f = 2'b10;
            2'b11:        sgn_f = 2'b00;
            default:      sgn_f = 2'b00;
        endcase
        return sgn_f;
    endfunction

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [3:0]  cnt_r;
    logic [1:0]  op_r;
    logic        neg_res_r;
    logic [31:0] rs1_r;
    logic [31:0] rs2_r;
    logic [1:0]  sgn_r;
    logic        cache_vld_r;
    logic [63:0] prod_r;

    logic [1:0]  sgn_s;
    logic        neg_a_s;
    logic        neg_b_s;
    logic        hit_s;

    // rs1_r/rs2_r/sgn_r/prod_r double as the cache contents: they are only
    // overwritten by a miss, which also clears cache_vld_r.
    assign sgn_s   = op_signedness(op);
    assign neg_a_s = sgn_s[1] & rs1[31];
    assign neg_b_s = sgn_s[0] & rs2[31];
    assign hit_s   = cache_vld_r && (rs1 == rs1_r) && (rs2 == rs2_r) &&
                     ((op == OP_MUL) || (sgn_s == sgn_r));

    // Next-state decode; flush overrides every state
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt_s = hit_s ? ST_DONE : ST_WAIT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd1) begin
                        state_nxt_s = ST_FIX;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_FIX:  state_nxt_s = ST_DONE;
                ST_DONE: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State, latency counter and the registered busy/done status outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy    <= !flush && ((state_r == ST_WAIT) || (state_r == ST_FIX));
            done    <= !flush && (state_r == ST_DONE);
            if (flush) begin
                cnt_r <= 4'd0;
            end else if ((state_r == ST_IDLE) && start && !hit_s) begin
                cnt_r <= LAT_INIT;
            end else if (state_r == ST_WAIT) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Operand capture, product capture/sign fix, result select and cache valid
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mul_a       <= 32'd0;
            mul_b       <= 32'd0;
            result      <= 32'd0;
            op_r        <= 2'd0;
            neg_res_r   <= 1'b0;
            rs1_r       <= 32'd0;
            rs2_r       <= 32'd0;
            sgn_r       <= 2'd0;
            prod_r      <= 64'd0;
            cache_vld_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !flush) begin
                        op_r <= op;
                        if (!hit_s) begin
                            mul_a       <= neg_a_s ? (~rs1 + 32'd1) : rs1;
                            mul_b       <= neg_b_s ? (~rs2 + 32'd1) : rs2;
                            neg_res_r   <= neg_a_s ^ neg_b_s;
                            rs1_r       <= rs1;
                            rs2_r       <= rs2;
                            sgn_r       <= sgn_s;
                            cache_vld_r <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!flush && (cnt_r == 4'd1)) begin
                        prod_r <= mul_out;
                    end
                end
                ST_FIX: begin
                    if (!flush) begin
                        prod_r      <= neg_res_r ? (~prod_r + 64'd1) : prod_r;
                        cache_vld_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!flush) begin
                        result <= (op_r == OP_MUL) ? prod_r[31:0] : prod_r[63:32];
                    end
                end
                default: begin
                    cache_vld_r <= 1'b0;
                end
            endcase
            // Any flush discards the cached product, whatever the state
            if (flush) begin
                cache_vld_r <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
Sequencing and sign-handling front/back end for the unsigned 32x32->64 multiplier in the RV32M execute path.
- Upstream: accepts a MUL/MULH/MULHSU/MULHU request from execute and converts the signed operands to magnitudes.
- Drives the multiplier operands and waits its fixed latency.
- Downstream: consumes the 64-bit product, applies sign correction, selects the low or high half and returns the result with a done pulse.
- Holds a one-entry operand cache, so a MULH followed by a MUL on the same operands completes in one cycle.

Parameters:
MUL_LATENCY, 4, cycles from stable mul_a/mul_b to valid mul_out; legal range 1..15.

Ports:
clk  in  1  clock, rising edge
nrst  in  1  asynchronous active-low reset
start  in  1  one-cycle request pulse; sampled only in IDLE
flush  in  1  abort the current op (pipeline flush)
op  in  2  funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
rs1  in  32  operand A; sampled with start
rs2  in  32  operand B; sampled with start
busy  out  1  high while an op is in flight (WAIT, FIX)
done  out  1  one-cycle pulse; result valid in that cycle
result  out  32  registered; held until the next done
mul_a  out  32  magnitude of operand A to the multiplier; registered
mul_b  out  32  magnitude of operand B to the multiplier; registered
mul_out  in  64  unsigned product from the multiplier

Behaviour:
- Reset (async, nrst=0): state=IDLE; busy, done, result, mul_a, mul_b = 0; cache invalid; counter=0.
- States: IDLE, WAIT, FIX, DONE.
- Signedness per op:
  - MUL/MULH: A signed, B signed.
  - MULHSU: A signed, B unsigned.
  - MULHU: both unsigned.
- neg_a = signed_a & rs1[31]; neg_b likewise; neg_res = neg_a ^ neg_b.
- Magnitudes: mul_a = neg_a ? -rs1 : rs1 (32-bit two's complement). 0x80000000 negates to 0x80000000, which is the correct unsigned magnitude.
- IDLE + start, cache hit: go to DONE. done is asserted the next cycle, with the result selected from the cached corrected product.
- Cache hit definition: cache valid, rs1 and rs2 equal the cached operands, and either op==MUL or signedness(op) equals the cached signedness. The low 32 bits are signedness-independent.
- IDLE + start, no hit:
  - Register mul_a, mul_b, op and neg_res; load counter = MUL_LATENCY; go to WAIT.
  - Cache is invalidated at this point.
- WAIT:
  - mul_a/mul_b are held stable.
  - Counter decrements each cycle.
  - When counter reaches 1, capture mul_out into the 64-bit prod register; next state FIX.
  - WAIT lasts exactly MUL_LATENCY cycles.
- FIX:
  - prod = neg_res ? (~prod + 1) : prod, full 64-bit.
  - Cache loads {rs1, rs2, signedness, prod} and is marked valid.
  - Next state DONE.
- DONE:
  - result = (op==MUL) ? prod[31:0] : prod[63:32]; done=1 for exactly one cycle; busy=0.
  - Unconditional return to IDLE.
- Latency:
  - Miss: start sampled at edge 0; done high in the cycle after edge MUL_LATENCY+2.
  - Hit: done high in the cycle after edge 1.
- busy: 1 in WAIT and FIX; 0 in IDLE and DONE.
- start asserted outside IDLE (including the DONE cycle) is ignored; no queuing.
- flush:
  - Any state except IDLE goes to IDLE on the next edge; no done; result unchanged.
  - Cache is invalidated.
  - flush in IDLE invalidates the cache only.
  - flush and start in the same IDLE cycle: flush wins; the request is dropped.
- Reset mid-operation: immediate return to reset values; no done.
- mul_a/mul_b retain their last value in IDLE, to avoid needless multiplier toggling.

Test Plan:
1. MUL rs1=7, rs2=0xFFFFFFFD, MUL_LATENCY=4 -> result 0xFFFFFFEB; done exactly 6 cycles after the start edge; busy high for cycles 1-5 only.
2. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU with the same operands -> 0x40000000 via full latency (signedness differs, so miss). MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. Then MUL with the same operands -> 0x00000001, done 1 cycle after start, mul_a/mul_b not reloaded.
4. MULH 5 x -1 with flush asserted 2 cycles after start -> no done; busy=0 next cycle; result unchanged. Reissued MULH 5 x -1 takes the full 6 cycles (cache invalid) -> 0xFFFFFFFF.
5. start pulses during WAIT and in the DONE cycle -> ignored, exactly one done. nrst pulsed low during FIX -> all outputs 0 immediately, no done after release.
6. 1000 random ops/operands (MUL_LATENCY 1 and 4, random flush at 5%) against a behavioural RV32M model -> every done result matches; done count equals non-flushed starts.
